// File: rtl/exception_controller_pkg.sv
// Shared types for the exception controller: FSM states, cause codes and
// the set of legal opcodes (opcode = instr[15:12]).
package exc_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    FLUSH   = 3'd1,
    VECTOR  = 3'd2,
    HANDLER = 3'd3,
    HALT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_OVF     = 2'd2,
    CAUSE_DOUBLE  = 2'd3
  } cause_t;

  localparam logic [3:0] OP_LEGAL_0 = 4'h0;
  localparam logic [3:0] OP_LEGAL_4 = 4'h4;
  localparam logic [3:0] OP_LEGAL_5 = 4'h5;
  localparam logic [3:0] OP_LEGAL_6 = 4'h6;
  localparam logic [3:0] OP_LEGAL_8 = 4'h8;
  localparam logic [3:0] OP_LEGAL_B = 4'hB;
  localparam logic [3:0] OP_LEGAL_C = 4'hC;
  localparam logic [3:0] OP_LEGAL_F = 4'hF;

endpackage

// File: rtl/exception_controller_if.sv
// Datapath <-> exception controller signal bundle.
// With EXC_OVF_MASK_EN defined, an extra ovf_mask input is carried.
interface exception_controller_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
);
  logic             instr_valid;
  logic [15:0]      instr;
  logic [PC_W-1:0]  instr_pc;
  logic             overflow;
  logic             eret_req;
`ifdef EXC_OVF_MASK_EN
  logic             ovf_mask;
`endif
  logic             stall;
  logic             flush;
  logic             pc_load;
  logic [PC_W-1:0]  pc_load_addr;
  logic [PC_W-1:0]  epc;
  logic [1:0]       cause;
  logic             exc_active;
  logic             halt;
  logic [CNT_W-1:0] exc_count;

  modport master (
`ifdef EXC_OVF_MASK_EN
    output ovf_mask,
`endif
    output instr_valid, instr, instr_pc, overflow, eret_req,
    input  stall, flush, pc_load, pc_load_addr, epc, cause,
    input  exc_active, halt, exc_count
  );

  modport slave (
`ifdef EXC_OVF_MASK_EN
    input  ovf_mask,
`endif
    input  instr_valid, instr, instr_pc, overflow, eret_req,
    output stall, flush, pc_load, pc_load_addr, epc, cause,
    output exc_active, halt, exc_count
  );
endinterface

// File: rtl/exception_controller_opcode_legal_check.sv
// Combinational legal-opcode decoder for the 4-bit major opcode.
module opcode_legal_check
  import exc_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LEGAL_0, OP_LEGAL_4, OP_LEGAL_5, OP_LEGAL_6,
      OP_LEGAL_8, OP_LEGAL_B, OP_LEGAL_C, OP_LEGAL_F: legal = 1'b1;
      default:                                        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/exception_controller.sv
// Exception sequencer: detect illegal opcode / overflow, flush, vector to the
// handler, return on eret, halt on double fault. Optional macro: EXC_OVF_MASK_EN.
module exception_controller
  import exc_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] VECTOR_ADDR = 16'hFFF0,
  parameter int              CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  exception_controller_if.slave  bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_nx;
  logic [PC_W-1:0]  epc_q, epc_nx;
  cause_t           cause_q, cause_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;

  logic legal;
  logic ovf_en;
  logic fault_ill, fault_ovf, fault;

  opcode_legal_check u_legal (
    .opcode (bus.instr[15:12]),
    .legal  (legal)
  );

`ifdef EXC_OVF_MASK_EN
  assign ovf_en = ~bus.ovf_mask;
`else
  assign ovf_en = 1'b1;
`endif

  // Illegal opcode wins, so overflow is only reported for legal opcodes.
  assign fault_ill = bus.instr_valid & ~legal;
  assign fault_ovf = bus.instr_valid &  legal & bus.overflow & ovf_en;
  assign fault     = fault_ill | fault_ovf;

  always_comb begin
    state_nx         = state_q;
    epc_nx           = epc_q;
    cause_nx         = cause_q;
    cnt_nx           = cnt_q;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.pc_load      = 1'b0;
    bus.pc_load_addr = '0;
    bus.exc_active   = 1'b0;
    bus.halt         = 1'b0;
    case (state_q)
      RUN: begin
        if (fault) begin
          epc_nx   = bus.instr_pc;
          cause_nx = fault_ill ? CAUSE_ILLEGAL : CAUSE_OVF;
          cnt_nx   = sat_inc(cnt_q);
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        state_nx  = VECTOR;
      end
      VECTOR: begin
        bus.stall        = 1'b1;
        bus.pc_load      = 1'b1;
        bus.pc_load_addr = VECTOR_ADDR;
        state_nx         = HANDLER;
      end
      HANDLER: begin
        bus.exc_active = 1'b1;
        // A fault in the handler outranks a same-cycle eret.
        if (fault) begin
          cause_nx = CAUSE_DOUBLE;
          cnt_nx   = sat_inc(cnt_q);
          state_nx = HALT;
        end else if (bus.eret_req && bus.instr_valid) begin
          bus.pc_load      = 1'b1;
          bus.pc_load_addr = epc_q + PC_W'(1);
          cause_nx         = CAUSE_NONE;
          state_nx         = RUN;
        end
      end
      HALT: begin
        bus.halt  = 1'b1;
        bus.stall = 1'b1;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      epc_q   <= epc_nx;
      cause_q <= cause_nx;
      cnt_q   <= cnt_nx;
    end
  end

  assign bus.epc       = epc_q;
  assign bus.cause     = cause_q;
  assign bus.exc_count = cnt_q;

endmodule

// File: tb/tb_exception_controller.sv
// Directed table-driven bench for exception_controller plus hand-written
// sequences for reset-in-VECTOR, counter saturation and overflow masking.
module tb_exception_controller;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        pc_load;
    logic [15:0] addr;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic        act;
    logic        halt;
    logic [7:0]  cnt;
  } out_t;

  typedef struct {
    logic        v;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        ovf;
    logic        eret;
    out_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  exception_controller_if bus ();

  exception_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic out_t mk(input int s, input int f, input int p,
                              input int a, input int e, input int c,
                              input int x, input int h, input int n);
    out_t o;
    o.stall   = 1'(s);
    o.flush   = 1'(f);
    o.pc_load = 1'(p);
    o.addr    = 16'(a);
    o.epc     = 16'(e);
    o.cause   = 2'(c);
    o.act     = 1'(x);
    o.halt    = 1'(h);
    o.cnt     = 8'(n);
    return o;
  endfunction

  function automatic out_t snap();
    out_t o;
    o.stall   = bus.stall;
    o.flush   = bus.flush;
    o.pc_load = bus.pc_load;
    o.addr    = bus.pc_load_addr;
    o.epc     = bus.epc;
    o.cause   = bus.cause;
    o.act     = bus.exc_active;
    o.halt    = bus.halt;
    o.cnt     = bus.exc_count;
    return o;
  endfunction

  task automatic row(input int v, input int instr, input int pc,
                     input int ovf, input int eret, input out_t e);
    vec_t r;
    r.v = 1'(v); r.instr = 16'(instr); r.pc = 16'(pc);
    r.ovf = 1'(ovf); r.eret = 1'(eret); r.exp = e;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [15:0] instr,
                       input logic [15:0] pc, input logic ovf, input logic eret);
    bus.instr_valid = v;
    bus.instr       = instr;
    bus.instr_pc    = pc;
    bus.overflow    = ovf;
    bus.eret_req    = eret;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    @(negedge clk);
    act = snap();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h (stall,flush,pc_load,addr,epc,cause,act,halt,cnt)",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic take_exc(input logic [15:0] pc);
    drive(1'b1, 16'h1234, pc, 1'b0, 1'b0); step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0); step();
    step();
    drive(1'b1, 16'h0000, 16'hFFF0, 1'b0, 1'b1); step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
`ifdef EXC_OVF_MASK_EN
    bus.ovf_mask = 1'b0;
`endif
    //   v  instr    pc       ovf eret  stall flush pcl addr     epc      cause act halt cnt
    row(1, 'h4123, 'h0010, 0, 0, mk(0, 0, 0, 0,       0,       0, 0, 0, 0));
    row(1, 'h8000, 'h0011, 0, 0, mk(0, 0, 0, 0,       0,       0, 0, 0, 0));
    row(1, 'hF0FF, 'h0012, 0, 0, mk(0, 0, 0, 0,       0,       0, 0, 0, 0));
    row(1, 'h1234, 'h0040, 0, 0, mk(0, 0, 0, 0,       0,       0, 0, 0, 0));
    row(1, 'h7000, 'h0044, 1, 0, mk(1, 1, 0, 0,       'h0040,  1, 0, 0, 1));
    row(1, 'h1234, 'h0045, 0, 0, mk(1, 0, 1, 'hFFF0,  'h0040,  1, 0, 0, 1));
    row(0, 'h0000, 'h0000, 0, 0, mk(0, 0, 0, 0,       'h0040,  1, 1, 0, 1));
    row(1, 'h0000, 'hFFF0, 0, 1, mk(0, 0, 1, 'h0041,  'h0040,  1, 1, 0, 1));
    row(1, 'h5001, 'h0100, 1, 0, mk(0, 0, 0, 0,       'h0040,  0, 0, 0, 1));
    row(0, 'h0000, 'h0000, 0, 0, mk(1, 1, 0, 0,       'h0100,  2, 0, 0, 2));
    row(0, 'h0000, 'h0000, 0, 0, mk(1, 0, 1, 'hFFF0,  'h0100,  2, 0, 0, 2));
    row(1, 'h4000, 'hFFF0, 0, 0, mk(0, 0, 0, 0,       'h0100,  2, 1, 0, 2));
    row(1, 'h0000, 'hFFF1, 0, 1, mk(0, 0, 1, 'h0101,  'h0100,  2, 1, 0, 2));
    row(0, 'h0000, 'h0000, 0, 1, mk(0, 0, 0, 0,       'h0100,  0, 0, 0, 2));
    row(1, 'h0000, 'h0102, 0, 1, mk(0, 0, 0, 0,       'h0100,  0, 0, 0, 2));
    row(1, 'h3000, 'hFFFF, 1, 0, mk(0, 0, 0, 0,       'h0100,  0, 0, 0, 2));
    row(0, 'h0000, 'h0000, 0, 0, mk(1, 1, 0, 0,       'hFFFF,  1, 0, 0, 3));
    row(0, 'h0000, 'h0000, 0, 0, mk(1, 0, 1, 'hFFF0,  'hFFFF,  1, 0, 0, 3));
    row(1, 'h0000, 'hFFF0, 0, 1, mk(0, 0, 1, 'h0000,  'hFFFF,  1, 1, 0, 3));
    row(1, 'h7000, 'h0200, 0, 0, mk(0, 0, 0, 0,       'hFFFF,  0, 0, 0, 3));
    row(0, 'h0000, 'h0000, 0, 0, mk(1, 1, 0, 0,       'h0200,  1, 0, 0, 4));
    row(0, 'h0000, 'h0000, 0, 0, mk(1, 0, 1, 'hFFF0,  'h0200,  1, 0, 0, 4));
    row(1, 'h2000, 'hFFF0, 0, 1, mk(0, 0, 0, 0,       'h0200,  1, 1, 0, 4));
    row(1, 'h1000, 'hFFF2, 0, 0, mk(1, 0, 0, 0,       'h0200,  3, 0, 1, 5));
    row(1, 'h0000, 'hFFF3, 0, 1, mk(1, 0, 0, 0,       'h0200,  3, 0, 1, 5));

    // Reset held for three edges
    rst = 1'b1;
    step();
    check("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(); step();
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].instr, vecs[i].pc, vecs[i].ovf, vecs[i].eret);
      check($sformatf("vec%0d", i), vecs[i].exp);
      step();
    end

    // Halt only clears on reset
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    check("halt_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset asserted during VECTOR
    drive(1'b1, 16'h1234, 16'h0050, 1'b0, 1'b0); step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0); step();
    rst = 1'b1;
    check("vector_pre", mk(1, 0, 1, 'hFFF0, 'h0050, 1, 0, 0, 1));
    step(); rst = 1'b0;
    check("vector_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();

    // Counter saturation
    for (int k = 0; k < 255; k++) take_exc(16'h0300);
    check("sat255", mk(0, 0, 0, 0, 'h0300, 0, 0, 0, 'hFF));
    drive(1'b1, 16'h1234, 16'h0301, 1'b0, 1'b0); step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("sat256", mk(1, 1, 0, 0, 'h0301, 1, 0, 0, 'hFF));
    rst = 1'b1; step(); rst = 1'b0;

`ifdef EXC_OVF_MASK_EN
    bus.ovf_mask = 1'b1;
    drive(1'b1, 16'h5001, 16'h0400, 1'b1, 1'b0); step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("mask_ovf", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1'b1, 16'h3000, 16'h0404, 1'b1, 1'b0); step();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("mask_ill", mk(1, 1, 0, 0, 'h0404, 1, 0, 0, 1));
    bus.ovf_mask = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
